// File: rtl/ex_stage.sv
// Execute stage: latches the decode bus on a valid/ready handshake, evaluates the
// one-hot ALU and issues the data-SRAM request for loads and stores.
module ex_stage #(
    parameter int ID_BUS_W = 150,
    parameter int EX_BUS_W = 71
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [ID_BUS_W-1:0] id_to_ex_bus,
    output logic                ex_allowin,
    output logic                ex_valid,
    input  logic                mem_allowin,
    output logic [EX_BUS_W-1:0] ex_to_mem_bus,
    output logic                data_sram_en,
    output logic [3:0]          data_sram_we,
    output logic [31:0]         data_sram_addr,
    output logic [31:0]         data_sram_wdata
);

    logic                ex_valid_r;
    logic [ID_BUS_W-1:0] payload;
    logic                ex_ready_go;

    logic [11:0] alu_op;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rj;
    logic [31:0] rkd;
    logic        src1_is_pc;
    logic        src2_is_imm;
    logic        res_from_mem;
    logic        gr_we;
    logic        mem_we;
    logic [4:0]  dest;

    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  shamt;
    logic        adder_inv;
    logic [31:0] adder_b;
    logic [32:0] adder_sum;
    logic        slt_res;
    logic        sltu_res;
    logic [31:0] sra_res;
    logic [31:0] alu_result;

    assign ex_ready_go = 1'b1;
    assign ex_allowin  = !ex_valid_r || (ex_ready_go && mem_allowin);
    assign ex_valid    = ex_valid_r && ex_ready_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_r <= 1'b0;
        end else if (ex_allowin) begin
            ex_valid_r <= id_valid;
        end
    end

    // Payload is deliberately not reset; it only matters while ex_valid_r is set.
    always_ff @(posedge clk) begin
        if (id_valid && ex_allowin) begin
            payload <= id_to_ex_bus;
        end
    end

    assign alu_op       = payload[149:138];
    assign pc           = payload[137:106];
    assign imm          = payload[105:74];
    assign rj           = payload[73:42];
    assign rkd          = payload[41:10];
    assign src1_is_pc   = payload[9];
    assign src2_is_imm  = payload[8];
    assign res_from_mem = payload[7];
    assign gr_we        = payload[6];
    assign mem_we       = payload[5];
    assign dest         = payload[4:0];

    assign src1  = src1_is_pc  ? pc  : rj;
    assign src2  = src2_is_imm ? imm : rkd;
    assign shamt = src2[4:0];

    // One 33-bit adder serves add, sub, slt and sltu; comparisons subtract.
    assign adder_inv = alu_op[1] | alu_op[2] | alu_op[3];
    assign adder_b   = adder_inv ? ~src2 : src2;
    assign adder_sum = {1'b0, src1} + {1'b0, adder_b} + {32'd0, adder_inv};
    assign slt_res   = (src1[31] & ~src2[31]) | (~(src1[31] ^ src2[31]) & adder_sum[31]);
    assign sltu_res  = ~adder_sum[32];
    assign sra_res   = 32'($signed(src1) >>> shamt);

    always_comb begin
        alu_result = 32'd0;
        if (alu_op[0])  alu_result = alu_result | adder_sum[31:0];
        if (alu_op[1])  alu_result = alu_result | adder_sum[31:0];
        if (alu_op[2])  alu_result = alu_result | {31'd0, slt_res};
        if (alu_op[3])  alu_result = alu_result | {31'd0, sltu_res};
        if (alu_op[4])  alu_result = alu_result | (src1 & src2);
        if (alu_op[5])  alu_result = alu_result | ~(src1 | src2);
        if (alu_op[6])  alu_result = alu_result | (src1 | src2);
        if (alu_op[7])  alu_result = alu_result | (src1 ^ src2);
        if (alu_op[8])  alu_result = alu_result | (src1 << shamt);
        if (alu_op[9])  alu_result = alu_result | (src1 >> shamt);
        if (alu_op[10]) alu_result = alu_result | sra_res;
        if (alu_op[11]) alu_result = alu_result | src2;
    end

    assign ex_to_mem_bus = {pc, res_from_mem, gr_we, dest, alu_result};

    // Gating with mem_allowin keeps a stalled store from issuing early or twice.
    assign data_sram_en    = ex_valid_r && (res_from_mem || mem_we) && mem_allowin;
    assign data_sram_we    = {4{ex_valid_r && mem_we && mem_allowin}};
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = rkd;

endmodule
